// File: rtl/mc_control_unit_pkg.sv
// Shared types and constants for the multicycle control unit: state encodings,
// opcode classes, datapath select values and the per-state output table.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RST     = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EX_R    = 4'd3,
        ST_EX_I    = 4'd4,
        ST_EX_IU   = 4'd5,
        ST_EX_ADDR = 4'd6,
        ST_EX_BR   = 4'd7,
        ST_EX_J    = 4'd8,
        ST_MEM_RD  = 4'd9,
        ST_MEM_WR  = 4'd10,
        ST_WB_R    = 4'd11,
        ST_WB_LW   = 4'd12,
        ST_TRAP    = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_IU  = 3'd2,
        CL_LD  = 3'd3,
        CL_ST  = 3'd4,
        CL_BR  = 3'd5,
        CL_J   = 3'd6,
        CL_ILL = 3'd7
    } op_class_t;

    localparam logic [3:0] OP_LUI = 4'b0000;
    localparam logic [3:0] OP_LW  = 4'b0001;
    localparam logic [3:0] OP_SW  = 4'b0010;
    localparam logic [3:0] OP_J   = 4'b0011;
    localparam logic [3:0] OP_BEQ = 4'b0100;
    localparam logic [3:0] OP_BNE = 4'b0101;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_TARGET = 2'b10;
    localparam logic [1:0] PC_SRC_TRAP   = 2'b11;

    localparam logic [2:0] SRCB_REG    = 3'b000;
    localparam logic [2:0] SRCB_FOUR   = 3'b001;
    localparam logic [2:0] SRCB_IMM_SL = 3'b011;
    localparam logic [2:0] SRCB_IMM    = 3'b100;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_IRQ     = 2'b10;

    // Outputs that depend on the state alone
    typedef struct packed {
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_to_reg;
        logic       pc_write;
        logic       branch;
        logic       trap;
        logic       retire;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t c;
        case (op)
            4'b1000, 4'b1100, 4'b1011, 4'b1111:                   c = CL_R;
            4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110: c = CL_I;
            OP_LUI:                                               c = CL_IU;
            OP_LW:                                                c = CL_LD;
            OP_SW:                                                c = CL_ST;
            OP_BEQ, OP_BNE:                                       c = CL_BR;
            OP_J:                                                 c = CL_J;
            default:                                              c = CL_ILL;
        endcase
        return c;
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.alu_op = ALUOP_ADD; end
            ST_DECODE:  c.alu_src_b = SRCB_IMM_SL;
            ST_EX_R:    begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG;    c.alu_op = ALUOP_FUNC; end
            ST_EX_I:    begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM;    c.alu_op = ALUOP_FUNC; end
            ST_EX_IU:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM_SL; c.alu_op = ALUOP_FUNC; end
            ST_EX_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM;    c.alu_op = ALUOP_ADD;  end
            ST_EX_BR:   begin
                c.branch = 1'b1; c.pc_src = PC_SRC_TARGET; c.alu_src_a = 1'b1;
                c.alu_op = ALUOP_SUB; c.retire = 1'b1;
            end
            ST_EX_J:    begin c.pc_src = PC_SRC_TARGET; c.pc_write = 1'b1; c.retire = 1'b1; end
            ST_MEM_RD:  begin c.i_or_d = 1'b1; c.mem_read = 1'b1; end
            ST_MEM_WR:  begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
            ST_WB_R:    begin c.reg_write = 1'b1; c.retire = 1'b1; end
            ST_WB_LW:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.reg_dst = 1'b1; c.retire = 1'b1; end
            ST_TRAP:    begin c.pc_src = PC_SRC_TRAP; c.pc_write = 1'b1; c.trap = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit to datapath bundle: instruction fields and memory status in,
// every mux select and enable out.
interface mc_control_unit_if #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned FUNC_W = 4
);
    logic [OP_W-1:0]   op;
    logic [FUNC_W-1:0] funcf;
    logic              mem_ready;
    logic              irq;

    logic [1:0]        pc_src;
    logic              i_or_d;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              reg_dst;
    logic              reg_src_a;
    logic              reg_write;
    logic              alu_src_a;
    logic              mem_to_reg;
    logic              pc_write;
    logic              branch;
    logic              branch_eq;
    logic [2:0]        alu_src_b;
    logic [1:0]        alu_op;
    logic [FUNC_W-1:0] alu_func;
    logic              trap;
    logic [1:0]        trap_cause;
    logic              retire;
    logic [3:0]        state_o;

    modport master (
        input  op, funcf, mem_ready, irq,
        output pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_src_a,
               reg_write, alu_src_a, mem_to_reg, pc_write, branch, branch_eq,
               alu_src_b, alu_op, alu_func, trap, trap_cause, retire, state_o
    );

    modport slave (
        output op, funcf, mem_ready, irq,
        input  pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_src_a,
               reg_write, alu_src_a, mem_to_reg, pc_write, branch, branch_eq,
               alu_src_b, alu_op, alu_func, trap, trap_cause, retire, state_o
    );
endinterface

// File: rtl/mc_control_unit_decode.sv
// Opcode classifier: low nibble selects the class, any set bit above [3:0]
// marks the opcode illegal.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic [OP_W-1:0] i_op,
    output op_class_t       o_class,
    output logic            o_illegal
);
    logic [3:0] w_low;
    logic       w_upper;

    assign w_low   = i_op[3:0];
    assign o_class = op_class(w_low);

    generate
        if (OP_W > 4) begin : g_upper
            assign w_upper = |i_op[OP_W-1:4];
        end else begin : g_exact
            assign w_upper = 1'b0;
        end
    endgenerate

    assign o_illegal = w_upper || (o_class == CL_ILL);
endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-style control FSM with memory wait states, trap entry for
// illegal opcodes and interrupts, and a per-instruction retire pulse.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned FUNC_W  = 4,
    parameter bit          TRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_unit_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl;
    logic       r_fetch_rd;
    logic       r_irq_take;
    logic [1:0] r_trap_cause;
    op_class_t  w_class;
    logic       w_illegal;
    logic       w_take;
    logic       w_fetch_go;
    logic       w_ldst;

    mc_opcode_decode #(.OP_W(OP_W)) u_decode (
        .i_op      (bus.op),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    // irq is only looked at on the edge that enters FETCH, never while waiting there
    assign w_take = TRAP_EN && bus.irq && (w_next == ST_FETCH) && (r_state != ST_FETCH);

    always_comb begin
        w_next = ST_RST;
        case (r_state)
            ST_RST:     w_next = ST_FETCH;
            ST_FETCH: begin
                if (r_irq_take)         w_next = ST_TRAP;
                else if (bus.mem_ready) w_next = ST_DECODE;
                else                    w_next = ST_FETCH;
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    w_next = TRAP_EN ? ST_TRAP : ST_FETCH;
                end else begin
                    case (w_class)
                        CL_R:         w_next = ST_EX_R;
                        CL_I:         w_next = ST_EX_I;
                        CL_IU:        w_next = ST_EX_IU;
                        CL_LD, CL_ST: w_next = ST_EX_ADDR;
                        CL_BR:        w_next = ST_EX_BR;
                        CL_J:         w_next = ST_EX_J;
                        default:      w_next = ST_FETCH;
                    endcase
                end
            end
            ST_EX_R, ST_EX_I, ST_EX_IU: w_next = ST_WB_R;
            ST_EX_ADDR: w_next = (w_class == CL_LD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:  w_next = bus.mem_ready ? ST_WB_LW : ST_MEM_RD;
            ST_MEM_WR:  w_next = bus.mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_EX_BR, ST_EX_J, ST_WB_R, ST_WB_LW, ST_TRAP: w_next = ST_FETCH;
            default:    w_next = ST_RST;
        endcase
    end

    // Lookahead: register the next state's outputs so they line up with the state
    always_comb begin
        w_ctrl = state_ctrl(w_next);
        if (w_take) w_ctrl.mem_read = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RST;
            r_ctrl       <= '0;
            r_fetch_rd   <= 1'b0;
            r_irq_take   <= 1'b0;
            r_trap_cause <= TC_NONE;
        end else begin
            r_state    <= w_next;
            r_ctrl     <= w_ctrl;
            r_fetch_rd <= (w_next == ST_FETCH) && !w_take;
            r_irq_take <= w_take;
            if (w_next == ST_TRAP)
                r_trap_cause <= (r_state == ST_FETCH) ? TC_IRQ : TC_ILLEGAL;
        end
    end

    assign w_fetch_go = r_fetch_rd && bus.mem_ready;
    assign w_ldst     = (r_state == ST_DECODE) && !w_illegal && ((w_class == CL_LD) || (w_class == CL_ST));

    assign bus.pc_src     = r_ctrl.pc_src;
    assign bus.i_or_d     = r_ctrl.i_or_d;
    assign bus.mem_read   = r_ctrl.mem_read;
    assign bus.mem_write  = r_ctrl.mem_write;
    assign bus.ir_write   = w_fetch_go;
    assign bus.reg_dst    = r_ctrl.reg_dst | w_ldst;
    assign bus.reg_src_a  = w_ldst;
    assign bus.reg_write  = r_ctrl.reg_write;
    assign bus.alu_src_a  = r_ctrl.alu_src_a;
    assign bus.mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.pc_write   = r_ctrl.pc_write | w_fetch_go;
    assign bus.branch     = r_ctrl.branch;
    // Low opcode bit separates beq (0100) from bne (0101)
    assign bus.branch_eq  = r_ctrl.branch & ~bus.op[0];
    assign bus.alu_src_b  = r_ctrl.alu_src_b;
    assign bus.alu_op     = r_ctrl.alu_op;
    assign bus.alu_func   = (r_state == ST_RST) ? FUNC_W'(0) : bus.funcf;
    assign bus.trap       = r_ctrl.trap;
    assign bus.trap_cause = r_trap_cause;
    assign bus.retire     = r_ctrl.retire | (r_ctrl.mem_write & bus.mem_ready);
    assign bus.state_o    = r_state;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a cycle-by-cycle vector table through
// every instruction class and trap path, plus reset and TRAP_EN=0 sequences.
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] pc_src;
        logic       i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_src_a;
        logic       reg_write, alu_src_a, mem_to_reg, pc_write, branch, branch_eq;
        logic [2:0] alu_src_b;
        logic [1:0] alu_op;
        logic       trap;
        logic [1:0] trap_cause;
        logic       retire;
        logic [3:0] alu_func;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic       irq;
        state_t     st;
        logic [1:0] cause;
        logic       nomem;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vq[$];

    mc_control_unit_if #(.OP_W(6), .FUNC_W(4)) bus0 ();
    mc_control_unit_if #(.OP_W(6), .FUNC_W(4)) bus1 ();

    mc_control_unit #(.OP_W(6), .FUNC_W(4), .TRAP_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master));
    mc_control_unit #(.OP_W(6), .FUNC_W(4), .TRAP_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic mr, input logic irq,
                       input state_t st, input logic [1:0] cause, input logic nomem);
        vec_t v;
        v.op = op; v.mr = mr; v.irq = irq; v.st = st; v.cause = cause; v.nomem = nomem;
        vq.push_back(v);
    endtask

    function automatic out_t sample0();
        out_t o;
        o.pc_src = bus0.pc_src;       o.i_or_d = bus0.i_or_d;       o.mem_read = bus0.mem_read;
        o.mem_write = bus0.mem_write; o.ir_write = bus0.ir_write;   o.reg_dst = bus0.reg_dst;
        o.reg_src_a = bus0.reg_src_a; o.reg_write = bus0.reg_write; o.alu_src_a = bus0.alu_src_a;
        o.mem_to_reg = bus0.mem_to_reg; o.pc_write = bus0.pc_write; o.branch = bus0.branch;
        o.branch_eq = bus0.branch_eq; o.alu_src_b = bus0.alu_src_b; o.alu_op = bus0.alu_op;
        o.trap = bus0.trap;           o.trap_cause = bus0.trap_cause; o.retire = bus0.retire;
        o.alu_func = bus0.alu_func;
        return o;
    endfunction

    // Reference output table, written directly from the state descriptions
    function automatic out_t model(input state_t s, input logic [5:0] op, input logic mr,
                                   input logic [1:0] cause, input logic nomem, input logic [3:0] fn);
        out_t o;
        o = '0;
        if (s != ST_RST) begin
            o.trap_cause = cause;
            o.alu_func   = fn;
        end
        case (s)
            ST_FETCH: begin
                o.mem_read = !nomem; o.alu_src_b = 3'b001;
                o.ir_write = mr && !nomem; o.pc_write = mr && !nomem;
            end
            ST_DECODE: begin
                o.alu_src_b = 3'b011;
                o.reg_dst   = (op == 6'h01) || (op == 6'h02);
                o.reg_src_a = (op == 6'h01) || (op == 6'h02);
            end
            ST_EX_R:    begin o.alu_src_a = 1; o.alu_src_b = 3'b000; o.alu_op = 2'b10; end
            ST_EX_I:    begin o.alu_src_a = 1; o.alu_src_b = 3'b100; o.alu_op = 2'b10; end
            ST_EX_IU:   begin o.alu_src_a = 1; o.alu_src_b = 3'b011; o.alu_op = 2'b10; end
            ST_EX_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 3'b100; o.alu_op = 2'b00; end
            ST_EX_BR: begin
                o.branch = 1; o.pc_src = 2'b10; o.alu_src_a = 1; o.alu_op = 2'b01; o.retire = 1;
                o.branch_eq = (op[3:0] == 4'b0100);
            end
            ST_EX_J:   begin o.pc_src = 2'b10; o.pc_write = 1; o.retire = 1; end
            ST_MEM_RD: begin o.i_or_d = 1; o.mem_read = 1; end
            ST_MEM_WR: begin o.i_or_d = 1; o.mem_write = 1; o.retire = mr; end
            ST_WB_R:   begin o.reg_write = 1; o.retire = 1; end
            ST_WB_LW:  begin o.reg_write = 1; o.mem_to_reg = 1; o.reg_dst = 1; o.retire = 1; end
            ST_TRAP:   begin o.pc_src = 2'b11; o.pc_write = 1; o.trap = 1; end
            default:   o = '0;
        endcase
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        bus0.op = '0; bus0.funcf = 4'h6; bus0.mem_ready = 1'b0; bus0.irq = 1'b0;
        bus1.op = '0; bus1.funcf = 4'h3; bus1.mem_ready = 1'b0; bus1.irq = 1'b0;
        reset = 1'b1;

        // R-type, load with two MEM_RD waits, store with fetch and MEM_WR waits
        add(6'h08,1,0,ST_RST,0,0);   add(6'h08,1,0,ST_FETCH,0,0);  add(6'h08,0,0,ST_DECODE,0,0);
        add(6'h08,0,0,ST_EX_R,0,0);  add(6'h08,1,0,ST_WB_R,0,0);
        add(6'h01,1,0,ST_FETCH,0,0); add(6'h01,0,0,ST_DECODE,0,0); add(6'h01,1,0,ST_EX_ADDR,0,0);
        add(6'h01,0,0,ST_MEM_RD,0,0); add(6'h01,0,0,ST_MEM_RD,0,0); add(6'h01,1,0,ST_MEM_RD,0,0);
        add(6'h01,0,0,ST_WB_LW,0,0);
        add(6'h02,0,0,ST_FETCH,0,0); add(6'h02,1,0,ST_FETCH,0,0);  add(6'h02,1,0,ST_DECODE,0,0);
        add(6'h02,1,0,ST_EX_ADDR,0,0); add(6'h02,0,0,ST_MEM_WR,0,0); add(6'h02,1,0,ST_MEM_WR,0,0);
        // beq, bne, jump, I-type, upper-immediate
        add(6'h04,1,0,ST_FETCH,0,0); add(6'h04,1,0,ST_DECODE,0,0); add(6'h04,1,0,ST_EX_BR,0,0);
        add(6'h05,1,0,ST_FETCH,0,0); add(6'h05,1,0,ST_DECODE,0,0); add(6'h05,1,0,ST_EX_BR,0,0);
        add(6'h03,1,0,ST_FETCH,0,0); add(6'h03,1,0,ST_DECODE,0,0); add(6'h03,1,0,ST_EX_J,0,0);
        add(6'h09,1,0,ST_FETCH,0,0); add(6'h09,1,0,ST_DECODE,0,0); add(6'h09,1,0,ST_EX_I,0,0);
        add(6'h09,1,0,ST_WB_R,0,0);
        add(6'h00,1,0,ST_FETCH,0,0); add(6'h00,1,0,ST_DECODE,0,0); add(6'h00,1,0,ST_EX_IU,0,0);
        add(6'h00,1,0,ST_WB_R,0,0);
        // Upper-bit illegal trap, then irq trap at FETCH entry, then irq mid-instruction
        add(6'h16,1,0,ST_FETCH,0,0); add(6'h16,1,0,ST_DECODE,0,0); add(6'h16,1,1,ST_TRAP,1,0);
        add(6'h16,1,0,ST_FETCH,1,1); add(6'h0F,1,0,ST_TRAP,2,0);   add(6'h0F,1,0,ST_FETCH,2,0);
        add(6'h0F,1,1,ST_DECODE,2,0); add(6'h0F,1,1,ST_EX_R,2,0);  add(6'h0F,1,0,ST_WB_R,2,0);
        add(6'h0F,0,0,ST_FETCH,2,0);

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset state", 32'(bus0.state_o), 32'(ST_RST));
        check("reset outputs", 32'(sample0()), 32'(model(ST_RST, 6'h00, 1'b0, 2'd0, 1'b0, 4'h6)));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            bus0.op = vq[i].op; bus0.mem_ready = vq[i].mr; bus0.irq = vq[i].irq;
            #1;
            check($sformatf("row%0d state", i), 32'(bus0.state_o), 32'(vq[i].st));
            check($sformatf("row%0d outputs", i), 32'(sample0()),
                  32'(model(vq[i].st, vq[i].op, vq[i].mr, vq[i].cause, vq[i].nomem, 4'h6)));
            @(negedge clk);
        end

        // Reset asserted mid store access
        bus0.op = 6'h02; bus0.mem_ready = 1'b1;
        #1 check("rs fetch", 32'(bus0.state_o), 32'(ST_FETCH));
        @(negedge clk); #1 check("rs decode", 32'(bus0.state_o), 32'(ST_DECODE));
        @(negedge clk); #1 check("rs exaddr", 32'(bus0.state_o), 32'(ST_EX_ADDR));
        bus0.mem_ready = 1'b0;
        @(negedge clk); #1 check("rs mem_write before", 32'(bus0.mem_write), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rs mem_write dropped", 32'(bus0.mem_write), 32'd0);
        check("rs state async", 32'(bus0.state_o), 32'(ST_RST));
        check("rs outputs zero", 32'(sample0()), 32'd0);
        @(negedge clk);
        reset = 1'b1; bus0.mem_ready = 1'b1;
        #1 check("rs rst after release", 32'(bus0.state_o), 32'(ST_RST));
        @(negedge clk); #1 check("rs fetch after release", 32'(bus0.state_o), 32'(ST_FETCH));

        // TRAP_EN=0: irq ignored at FETCH entry, illegal opcode acts as NOP
        bus1.op = 6'h16; bus1.mem_ready = 1'b1; bus1.irq = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 check("t0 rst", 32'(bus1.state_o), 32'(ST_RST));
        @(negedge clk); #1;
        check("t0 fetch", 32'(bus1.state_o), 32'(ST_FETCH));
        check("t0 mem_read", 32'(bus1.mem_read), 32'd1);
        check("t0 ir_write", 32'(bus1.ir_write), 32'd1);
        @(negedge clk); #1;
        check("t0 decode", 32'(bus1.state_o), 32'(ST_DECODE));
        check("t0 decode retire", 32'(bus1.retire), 32'd0);
        @(negedge clk); #1;
        check("t0 back to fetch", 32'(bus1.state_o), 32'(ST_FETCH));
        check("t0 fetch retire", 32'(bus1.retire), 32'd0);
        check("t0 trap", 32'(bus1.trap), 32'd0);
        check("t0 trap_cause", 32'(bus1.trap_cause), 32'd0);
        @(negedge clk); #1;
        check("t0 second decode", 32'(bus1.state_o), 32'(ST_DECODE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
